// File: rtl/instr_fetch_pkg.sv
// Shared constants and the prefetch queue entry layout for the instruction fetch unit.
package instr_fetch_pkg;

   localparam int unsigned XLEN        = 32;
   localparam int unsigned INSTR_BYTES = 4;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_fifo.sv
// Prefetch queue: power-of-two circular buffer with synchronous reset and flush.
module fetch_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     rst_i,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     empty_o,
   output logic                     full_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;

   always_ff @(posedge clk) begin
      if (rst_i || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         // Pointers are exactly AW bits wide, so the increment wraps modulo DEPTH.
         if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_i && !rst_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == FULL_CNT);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC register driving instr_memory, prefetch queue, redirect and misalign tracking.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic                   clk,
   input  logic                   reset_pc,
   output logic [XLEN-1:0]        im_addr,
   input  logic [XLEN-1:0]        im_data,
   input  logic                   redirect_valid,
   input  logic [XLEN-1:0]        redirect_pc,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [XLEN-1:0]        out_instr,
   output logic [XLEN-1:0]        out_pc,
   output logic [$clog2(DEPTH):0] out_count,
   output logic                   misalign
);

   logic [XLEN-1:0] pc_q, pc_d;
   logic            misalign_q, misalign_d;
   logic            push, pop, q_empty, q_full;
   fetch_entry_t    push_entry, head_entry;

   assign pop  = !q_empty && out_ready && !redirect_valid;
   assign push = !redirect_valid && (!q_full || pop);
   assign push_entry = '{pc: pc_q, instr: im_data};

   always_comb begin
      pc_d       = pc_q;
      misalign_d = misalign_q;
      if (redirect_valid) begin
         pc_d = {redirect_pc[XLEN-1:2], 2'b00};
         if (redirect_pc[1:0] != 2'b00) misalign_d = 1'b1;
      end else if (push) begin
         pc_d = pc_q + XLEN'(INSTR_BYTES);
      end
   end

   always_ff @(posedge clk) begin
      if (reset_pc) begin
         pc_q       <= RESET_PC;
         misalign_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         misalign_q <= misalign_d;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(fetch_entry_t))
   ) u_fifo (
      .clk     (clk),
      .rst_i   (reset_pc),
      .flush_i (redirect_valid),
      .push_i  (push),
      .wdata_i (push_entry),
      .pop_i   (pop),
      .rdata_o (head_entry),
      .count_o (out_count),
      .empty_o (q_empty),
      .full_o  (q_full)
   );

   assign im_addr   = pc_q;
   assign out_valid = !q_empty;
   assign out_instr = q_empty ? NOP_INSTR : head_entry.instr;
   assign out_pc    = q_empty ? pc_q : head_entry.pc;
   assign misalign  = misalign_q;

endmodule
